bus_arbiter: RTL

Two-master arbiter and slave-select controller for the system bus. It grants the shared bus to master 1 or master 2 with round-robin fairness, latches the target slave and drives its one-hot enable. It withholds grants targeting a busy slave and force-releases a master that holds the bus longer than `MAX_HOLD` cycles. It sits between the master ports and the bus mux/decoder in `top`.

---
 rtl/bus_arbiter_pkg.sv | 25 ++
 rtl/arb_hold_timer.sv | 41 ++++
 rtl/bus_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
//   Shared definitions for the system-bus arbiter and the blocks around it.
//   Contents:
//     state_t      - arbiter FSM states (IDLE=0, OWN=1)
//     master_t     - master identifiers (M1=0, M2=1)
//     DEF_NUM_SLV  - default number of slaves on the bus
//     DEF_SLV_W    - default width of a slave-select field
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    typedef enum logic {
        M1 = 1'b0,
        M2 = 1'b1
    } master_t;

    localparam int DEF_NUM_SLV = 3;
    localparam int DEF_SLV_W   = 2;

endpackage : bus_arbiter_pkg

// File: rtl/arb_hold_timer.sv
// -----------------------------------------------------------------------------
// arb_hold_timer
//   Counts the cycles of the current bus grant. Saturates at MAX_HOLD-1 and
//   flags expiry there; it never wraps.
//   Parameters:
//     MAX_HOLD - maximum number of cycles one grant may last (>= 2)
//   Ports:
//     clock    in  1  rising-edge clock
//     rst      in  1  synchronous active-high reset
//     clear    in  1  force the count to zero (held while the bus is idle)
//     enable   in  1  advance the count by one (while a grant is active)
//     expired  out 1  count has reached MAX_HOLD-1
// -----------------------------------------------------------------------------
module arb_hold_timer #(
    parameter int MAX_HOLD = 1024
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW    = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

    logic [CW-1:0] hold_cnt;

    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples the pre-edge value of its inputs.
    always_ff @(posedge clock) begin
        if (rst || clear) begin
            hold_cnt <= '0;
        end else if (enable && !expired) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign expired = (hold_cnt == LIMIT);

endmodule : arb_hold_timer

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Two-master round-robin arbiter and slave-select controller. Grants the
//   shared bus to one master at a time, latches its target slave, drives the
//   one-hot slave enable, withholds grants to busy or nonexistent slaves and
//   force-releases a master that holds the bus for MAX_HOLD cycles.
//   Parameters:
//     NUM_SLV  - number of slaves (1..4)
//     SLV_W    - width of the slave-select fields
//     MAX_HOLD - maximum cycles one grant may last (>= 2)
//   Ports:
//     clock              in  1        rising-edge clock
//     rst                in  1        synchronous active-high reset
//     m1_req, m2_req     in  1        bus request, held for the whole transfer
//     m1_sel, m2_sel     in  SLV_W    target slave, valid while req is high
//     slv_busy           in  NUM_SLV  bit i set: slave i refuses new transfers
//     m1_grant, m2_grant out 1        registered, mutually exclusive grants
//     bus_sel            out 1        bus mux select (0=M1, 1=M2)
//     slv_en             out NUM_SLV  one-hot enable of the latched slave
//     bus_busy           out 1        a grant is active
//     m1_abort, m2_abort out 1        one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_SLV  = DEF_NUM_SLV,
    parameter int SLV_W    = DEF_SLV_W,
    parameter int MAX_HOLD = 1024
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               m1_req,
    input  logic               m2_req,
    input  logic [SLV_W-1:0]   m1_sel,
    input  logic [SLV_W-1:0]   m2_sel,
    input  logic [NUM_SLV-1:0] slv_busy,
    output logic               m1_grant,
    output logic               m2_grant,
    output logic               bus_sel,
    output logic [NUM_SLV-1:0] slv_en,
    output logic               bus_busy,
    output logic               m1_abort,
    output logic               m2_abort
);

    state_t           state;
    master_t          last_owner;
    logic             lock_1;
    logic             lock_2;
    logic [SLV_W-1:0] cur_slv;

    logic m1_tgt_busy;
    logic m2_tgt_busy;
    logic m1_elig;
    logic m2_elig;
    logic grant_m1;
    logic grant_m2;
    logic owner_req;
    logic expired;

    arb_hold_timer #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_timer (
        .clock   (clock),
        .rst     (rst),
        .clear   (state == IDLE),
        .enable  (state == OWN),
        .expired (expired)
    );

    // Eligibility: request up, target exists, target idle, master not locked
    // out by a previous forced release.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        m1_tgt_busy = 1'b0;
        m2_tgt_busy = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (m1_sel == SLV_W'(i)) m1_tgt_busy = slv_busy[i];
            if (m2_sel == SLV_W'(i)) m2_tgt_busy = slv_busy[i];
        end
        m1_elig = m1_req && (int'(m1_sel) < NUM_SLV) && !m1_tgt_busy && !lock_1;
        m2_elig = m2_req && (int'(m2_sel) < NUM_SLV) && !m2_tgt_busy && !lock_2;
        // On a tie the master that did not own the bus last wins.
        grant_m2 = m2_elig && (!m1_elig || (last_owner == M1));
        grant_m1 = m1_elig && !grant_m2;
    end

    assign owner_req = (last_owner == M1) ? m1_req : m2_req;

    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= M2;
            lock_1     <= 1'b0;
            lock_2     <= 1'b0;
            cur_slv    <= '0;
            m1_grant   <= 1'b0;
            m2_grant   <= 1'b0;
            bus_sel    <= 1'b0;
            bus_busy   <= 1'b0;
            m1_abort   <= 1'b0;
            m2_abort   <= 1'b0;
        end else begin
            m1_abort <= 1'b0;
            m2_abort <= 1'b0;
            // A lock only lasts until the master lets go of its request.
            if (!m1_req) lock_1 <= 1'b0;
            if (!m2_req) lock_2 <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_m1) begin
                        state      <= OWN;
                        last_owner <= M1;
                        cur_slv    <= m1_sel;
                        m1_grant   <= 1'b1;
                        bus_sel    <= 1'b0;
                        bus_busy   <= 1'b1;
                    end else if (grant_m2) begin
                        state      <= OWN;
                        last_owner <= M2;
                        cur_slv    <= m2_sel;
                        m2_grant   <= 1'b1;
                        bus_sel    <= 1'b1;
                        bus_busy   <= 1'b1;
                    end
                end

                OWN: begin
                    // A release on the expiry edge is a normal release, so
                    // the owner's request is tested before the timer.
                    if (!owner_req || expired) begin
                        state    <= IDLE;
                        m1_grant <= 1'b0;
                        m2_grant <= 1'b0;
                        bus_sel  <= 1'b0;
                        bus_busy <= 1'b0;
                        if (owner_req) begin
                            if (last_owner == M1) begin
                                m1_abort <= 1'b1;
                                lock_1   <= 1'b1;
                            end else begin
                                m2_abort <= 1'b1;
                                lock_2   <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Slave enable is decoded from registered state only, so it changes
    // exactly with the grant and stays fixed for the whole ownership.
    always_comb begin
        slv_en = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (bus_busy && (cur_slv == SLV_W'(i))) slv_en[i] = 1'b1;
        end
    end

endmodule : bus_arbiter
